mlp_layer_seq: RTL

- Sequencer for the two-layer MLP datapath: input x W1 -> hidden, then hidden x W2 -> output.
- Drives weight and buffer addresses, plus accumulator clear/enable and write strobes, for one full inference per start.
- Sits between the host control interface and the MAC/activation datapath.
- Replaces free-running index counting with a start/busy/done handshake, stall and abort.

---
 rtl/mlp_pkg.sv | 27 ++
 rtl/mlp_wrap_cnt.sv | 29 ++
 rtl/mlp_layer_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared constants, state encoding and width helper
// for the two-layer MLP sequencer.
package mlp_pkg;

   localparam int MLP_N_IN  = 8;
   localparam int MLP_N_HID = 200;
   localparam int MLP_N_OUT = 10;
   localparam int MLP_WA_W  = 11;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int MLP_IN_W  = idx_w(MLP_N_IN);
   localparam int MLP_HID_W = idx_w(MLP_N_HID);
   localparam int MLP_OUT_W = idx_w(MLP_N_OUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_L1_MAC,
      S_L1_WB,
      S_L2_MAC,
      S_L2_WB,
      S_DONE
   } state_t;

endpackage

// File: rtl/mlp_wrap_cnt.sv
// Modulo-MAX index counter; wraps on the last
// compare, never by overflow.
import mlp_pkg::*;

module mlp_wrap_cnt #(
   parameter int MAX = 8,
   parameter int W   = idx_w(MAX)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] q,
   output logic         last
);

   assign last = (q == W'(MAX - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= last ? '0 : q + W'(1);
      end
   end

endmodule

// File: rtl/mlp_layer_seq.sv
// Start/busy/done sequencer driving weight and
// buffer addressing for one two-layer MLP inference.
import mlp_pkg::*;

module mlp_layer_seq #(
   parameter int N_IN  = MLP_N_IN,
   parameter int N_HID = MLP_N_HID,
   parameter int N_OUT = MLP_N_OUT,
   parameter int WA_W  = MLP_WA_W,
   localparam int IN_W  = idx_w(N_IN),
   localparam int HID_W = idx_w(N_HID),
   localparam int OUT_W = idx_w(N_OUT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             stall,
   output logic             busy,
   output logic             done,
   output logic             phase,
   output logic [WA_W-1:0]  w_addr,
   output logic [IN_W-1:0]  in_idx,
   output logic [HID_W-1:0] hid_idx,
   output logic [OUT_W-1:0] out_idx,
   output logic             acc_clr,
   output logic             acc_en,
   output logic             hid_we,
   output logic             out_we
);

   state_t st;

   logic i_last, h_last, o_last;
   logic live, kill, go, cnt_clr;
   logic i_en, h_en, o_en;
   logic mac;

   assign live    = (st != S_IDLE);
   assign kill    = abort && live;
   assign go      = live && !stall && !abort;
   assign cnt_clr = kill || (st == S_IDLE) || (st == S_DONE);

   assign i_en = go && (st == S_L1_MAC);
   assign h_en = go && ((st == S_L1_WB) || (st == S_L2_MAC));
   assign o_en = go && (st == S_L2_WB);

   mlp_wrap_cnt #(.MAX(N_IN), .W(IN_W)) u_i (
      .clk  (clk),
      .rst  (rst),
      .en   (i_en),
      .clr  (cnt_clr),
      .q    (in_idx),
      .last (i_last)
   );

   mlp_wrap_cnt #(.MAX(N_HID), .W(HID_W)) u_h (
      .clk  (clk),
      .rst  (rst),
      .en   (h_en),
      .clr  (cnt_clr),
      .q    (hid_idx),
      .last (h_last)
   );

   mlp_wrap_cnt #(.MAX(N_OUT), .W(OUT_W)) u_o (
      .clk  (clk),
      .rst  (rst),
      .en   (o_en),
      .clr  (cnt_clr),
      .q    (out_idx),
      .last (o_last)
   );

   // w_addr walks linearly through each weight matrix
   always_ff @(posedge clk) begin
      if (!rst) begin
         st     <= S_IDLE;
         phase  <= 1'b0;
         w_addr <= '0;
      end else if (kill) begin
         st     <= S_IDLE;
         phase  <= 1'b0;
         w_addr <= '0;
      end else if (!(stall && live)) begin
         unique case (st)
            S_IDLE: begin
               phase  <= 1'b0;
               w_addr <= '0;
               if (start) st <= S_L1_MAC;
            end
            S_L1_MAC: begin
               w_addr <= w_addr + WA_W'(1);
               if (i_last) st <= S_L1_WB;
            end
            S_L1_WB: begin
               if (h_last) begin
                  w_addr <= '0;
                  phase  <= 1'b1;
                  st     <= S_L2_MAC;
               end else begin
                  st <= S_L1_MAC;
               end
            end
            S_L2_MAC: begin
               w_addr <= w_addr + WA_W'(1);
               if (h_last) st <= S_L2_WB;
            end
            S_L2_WB: begin
               st <= o_last ? S_DONE : S_L2_MAC;
            end
            S_DONE: begin
               phase  <= 1'b0;
               w_addr <= '0;
               st     <= S_IDLE;
            end
            default: begin
               phase  <= 1'b0;
               w_addr <= '0;
               st     <= S_IDLE;
            end
         endcase
      end
   end

   assign mac  = (st == S_L1_MAC) || (st == S_L2_MAC);
   assign busy = live;
   assign done = (st == S_DONE);

   // strobes drop in any stalled cycle; done stays up
   assign acc_en  = mac && !stall;
   assign acc_clr = acc_en &&
                    ((st == S_L1_MAC) ? (in_idx == '0)
                                      : (hid_idx == '0));
   assign hid_we  = (st == S_L1_WB) && !stall;
   assign out_we  = (st == S_L2_WB) && !stall;

endmodule
